// File: rtl/pift_taint_monitor.sv
// Taint monitor beside SOC_TOP: registered taint count/peak, first-taint timestamp, threshold trigger
// and an event FIFO of newly tainted sources. Macro PIFT_MON_FALL_EN also logs falling-edge events.
module pift_taint_monitor #(
    parameter int N_SRC  = 16,
    parameter int CNT_W  = 5,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic              stop_on_thresh,
    input  logic [CNT_W-1:0]  thresh,
    input  logic [N_SRC-1:0]  taint_sum,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [N_SRC-1:0]  ev_mask,
    output logic [TS_W-1:0]   ev_ts,
    output logic              ev_fall,
    output logic [CNT_W-1:0]  taint_count,
    output logic [CNT_W-1:0]  taint_peak,
    output logic              first_valid,
    output logic [TS_W-1:0]   first_ts,
    output logic              triggered,
    output logic              overflow,
    output logic [DROP_W-1:0] dropped,
    output logic [1:0]        state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;
    localparam int AW = $clog2(DEPTH);

    logic [N_SRC-1:0] clean, prev, rise;
    logic [CNT_W-1:0] pop_cnt;
    logic [TS_W-1:0]  ts;
    logic [1:0]       next_state;
    logic             hit, running;

    logic [N_SRC-1:0] mem_mask [DEPTH];
    logic [TS_W-1:0]  mem_ts   [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             fifo_full, do_pop, do_push;
    logic             push_req;
    logic [N_SRC-1:0] push_mask;
    logic [TS_W-1:0]  push_ts;
    logic [1:0]       drop_inc;
    logic [DROP_W:0]  drop_sum;

    // Unknown taint bits count as clean; case matching keeps X/Z out of prev and rise.
    always_comb begin
        clean   = '0;
        pop_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            case (taint_sum[i])
                1'b1:    clean[i] = 1'b1;
                default: clean[i] = 1'b0;
            endcase
            pop_cnt = pop_cnt + CNT_W'(clean[i]);
        end
    end

    assign rise      = clean & ~prev;
    assign running   = (state == RUN);
    assign hit       = (thresh != '0) && (pop_cnt >= thresh);
    assign ev_valid  = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop    = ev_valid && ev_ready;
    assign do_push   = push_req && (!fifo_full || do_pop);
    assign ev_mask   = ev_valid ? mem_mask[rd_ptr[AW-1:0]] : '0;
    assign ev_ts     = ev_valid ? mem_ts[rd_ptr[AW-1:0]] : '0;
    assign drop_sum  = {1'b0, dropped} + {{(DROP_W-1){1'b0}}, drop_inc};

`ifdef PIFT_MON_FALL_EN
    logic [N_SRC-1:0] fall, hold_mask;
    logic [TS_W-1:0]  hold_ts;
    logic             hold_valid, hold_load, hold_drain, fall_drop, push_fall;
    logic             mem_fall [DEPTH];

    assign fall = ~clean & prev;

    // A rise always goes straight to the FIFO; a fall that cannot go this cycle waits in the hold slot.
    always_comb begin
        push_req   = 1'b0;
        push_mask  = rise;
        push_ts    = ts;
        push_fall  = 1'b0;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        fall_drop  = 1'b0;
        if (running) begin
            if (rise != '0) begin
                push_req = 1'b1;
                if (fall != '0) begin
                    if (hold_valid) fall_drop = 1'b1;
                    else            hold_load = 1'b1;
                end
            end else if (hold_valid) begin
                push_req   = 1'b1;
                push_mask  = hold_mask;
                push_ts    = hold_ts;
                push_fall  = 1'b1;
                hold_drain = 1'b1;
                hold_load  = (fall != '0);
            end else if (fall != '0) begin
                push_req  = 1'b1;
                push_mask = fall;
                push_fall = 1'b1;
            end
        end
    end

    assign drop_inc = {1'b0, push_req && !do_push} + {1'b0, fall_drop};
    assign ev_fall  = ev_valid && mem_fall[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_mask  <= '0;
            hold_ts    <= '0;
        end else if (hold_load) begin
            hold_valid <= 1'b1;
            hold_mask  <= fall;
            hold_ts    <= ts;
        end else if (hold_drain) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_fall[wr_ptr[AW-1:0]] <= push_fall;
    end
`else
    assign push_req  = running && (rise != '0);
    assign push_mask = rise;
    assign push_ts   = ts;
    assign drop_inc  = {1'b0, push_req && !do_push};
    assign ev_fall   = 1'b0;
`endif

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: next_state = enable ? RUN : IDLE;
            RUN: begin
                if (!enable)                   next_state = IDLE;
                else if (hit && stop_on_thresh) next_state = STOP;
                else                           next_state = RUN;
            end
            STOP:    next_state = enable ? STOP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Storage is not reset; the read side is masked by ev_valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_mask[wr_ptr[AW-1:0]] <= push_mask;
            mem_ts[wr_ptr[AW-1:0]]   <= push_ts;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ts          <= '0;
            prev        <= '0;
            taint_count <= '0;
            taint_peak  <= '0;
            first_valid <= 1'b0;
            first_ts    <= '0;
            triggered   <= 1'b0;
            overflow    <= 1'b0;
            dropped     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= next_state;
            prev        <= clean;
            taint_count <= pop_cnt;
            if (pop_cnt > taint_peak) taint_peak <= pop_cnt;
            if (running) begin
                ts <= ts + TS_W'(1);
                if (clean != '0 && !first_valid) begin
                    first_valid <= 1'b1;
                    first_ts    <= ts;
                end
                if (hit) triggered <= 1'b1;
            end
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop_inc != 2'd0) begin
                overflow <= 1'b1;
                dropped  <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end
        end
    end
endmodule
